// File: rtl/ex_pkg.sv
// Shared constants, FSM encoding and factor table for the e^X product accumulator.
package ex_pkg;

  localparam int unsigned DW      = 26;
  localparam int unsigned FRAC    = 11;
  localparam int unsigned N_TERMS = 6;
  localparam int unsigned CODE_W  = 6;

  localparam logic [DW-1:0] ONE_Q = 26'h800;
  localparam logic [DW-1:0] SAT_Q = 26'h3FFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    MUL  = 2'b10
  } state_t;

  // round(e^i * 2^11), i = 0..10
  localparam logic [DW-1:0] EXP_TAB [0:10] = '{
    26'h0000800, 26'h00015BF, 26'h0003B1D, 26'h000A0AF,
    26'h001B4C9, 26'h004A34E, 26'h00C9B6E, 26'h0224511,
    26'h05D27AA, 26'h0FD38AC, 26'h2B053BA
  };

endpackage

// File: rtl/ex_factor_rom.sv
// Combinational factor lookup: 6-bit code {int_or_fra, i} -> Q15.11 constant.
module ex_factor_rom
  import ex_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DW-1:0]     factor
);

  always_comb begin
    factor = ONE_Q;
    if (code[5]) begin
      case (code[4:0])
        5'd0:    factor = EXP_TAB[0];
        5'd1:    factor = EXP_TAB[1];
        5'd2:    factor = EXP_TAB[2];
        5'd3:    factor = EXP_TAB[3];
        5'd4:    factor = EXP_TAB[4];
        5'd5:    factor = EXP_TAB[5];
        5'd6:    factor = EXP_TAB[6];
        5'd7:    factor = EXP_TAB[7];
        5'd8:    factor = EXP_TAB[8];
        5'd9:    factor = EXP_TAB[9];
        5'd10:   factor = EXP_TAB[10];
        default: factor = SAT_Q;
      endcase
    end else if ((code[4:0] >= 5'd1) && (code[4:0] <= 5'd11)) begin
      // 1 + 2^-i
      factor = ONE_Q + (ONE_Q >> code[4:0]);
    end
  end

endmodule

// File: rtl/exp_product_accum.sv
// Serial product of six captured factor constants into a saturating Q15.11 accumulator.
module exp_product_accum
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mul_valid,
  input  logic [CODE_W-1:0] multiplier_0,
  input  logic [CODE_W-1:0] multiplier_1,
  input  logic [CODE_W-1:0] multiplier_2,
  input  logic [CODE_W-1:0] multiplier_3,
  input  logic [CODE_W-1:0] multiplier_4,
  input  logic [CODE_W-1:0] multiplier_5,
  output logic [DW-1:0]     exp_out,
  output logic              exp_valid,
  output logic              exp_sat,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q [N_TERMS];
  logic [2:0]          idx_q;
  logic [DW-1:0]       acc_q;
  logic                sat_q;

  logic [DW-1:0]       factor;
  logic [2*DW-1:0]     prod;
  logic [2*DW-1:0]     prod_rnd;
  logic                step_sat;
  logic [DW-1:0]       acc_step;
  logic                capture;
  logic                last_term;

  assign capture   = (state_q == IDLE) && mul_valid;
  assign last_term = (state_q == MUL) && (idx_q == 3'(N_TERMS - 1));

  ex_factor_rom u_rom (
    .code   (code_q[idx_q]),
    .factor (factor)
  );

  // Rounded product cannot overflow 52 bits: (2^26-1)^2 + 2^10 < 2^52.
  always_comb begin
    prod     = (2*DW)'(acc_q) * (2*DW)'(factor);
    prod_rnd = prod + ((2*DW)'(1) << (FRAC - 1));
    step_sat = |prod_rnd[2*DW-1:DW+FRAC];
    acc_step = step_sat ? SAT_Q : prod_rnd[DW+FRAC-1:FRAC];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_valid) state_d = MUL;
      MUL:     if (last_term) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_TERMS; k++) code_q[k] <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      exp_out   <= '0;
      exp_valid <= 1'b0;
      exp_sat   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      exp_valid <= 1'b0;
      if (capture) begin
        code_q[0] <= multiplier_0;
        code_q[1] <= multiplier_1;
        code_q[2] <= multiplier_2;
        code_q[3] <= multiplier_3;
        code_q[4] <= multiplier_4;
        code_q[5] <= multiplier_5;
        acc_q     <= ONE_Q;
        idx_q     <= '0;
        sat_q     <= 1'b0;
        busy      <= 1'b1;
      end else if (state_q == MUL) begin
        acc_q <= acc_step;
        sat_q <= sat_q | step_sat;
        idx_q <= idx_q + 3'd1;
        if (last_term) begin
          exp_out   <= acc_step;
          exp_sat   <= sat_q | step_sat;
          exp_valid <= 1'b1;
          busy      <= 1'b0;
          idx_q     <= '0;
        end
      end
    end
  end

endmodule
